// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_ctrl_pkg: shared types for the instruction-memory fetch controller.
//   imem_state_t  : controller state, encoding visible on state_o
//   fetch_entry_t : one buffered fetch response (instruction + its word PC)
package imem_ctrl_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } imem_state_t;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] instr;
    logic [IMEM_ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic imem_state_t reset_state(input bit boot_load);
    return boot_load ? ST_LOAD : ST_RUN;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: synchronous FIFO buffering memory read responses.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   push_i, wdata_i  : write one entry (ignored when full)
//   pop_i, rdata_o   : rdata_o is the head; pop_i removes it (ignored when empty)
//   flush_i          : empties the FIFO; has priority over push and pop
//   count_o, full_o, empty_o : occupancy status
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot loader / sequential fetch controller for a
// word-addressed instruction memory with fixed read latency RD_LAT.
//   clk, rst_n                         : clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_addr/ld_data  : loader write port (LOAD state only)
//   ld_done                            : loader finished, enter RUN
//   mem_addr/mem_re/mem_we/mem_wdata   : memory command port
//   mem_rdata                          : read data, RD_LAT cycles after mem_re
//   redirect/redirect_pc               : branch redirect pulse and target
//   halt                               : stop fetching until reset
//   if_valid/if_ready/if_instr/if_pc   : fetched-instruction handshake to IF/ID
//   state_o                            : current state (debug)
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0,
  parameter bit          BOOT_LOAD  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [IMEM_DATA_W-1:0] ld_data,
  input  logic                   ld_done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [IMEM_DATA_W-1:0] mem_wdata,
  input  logic [IMEM_DATA_W-1:0] mem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [IMEM_DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0]      if_pc,
  output logic [1:0]             state_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = IMEM_DATA_W + ADDR_W;

  imem_state_t       state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] tag_q [RD_LAT];

  logic              kill, flush, issue, pop, push;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, fifo_full_unused;
  logic [EW-1:0]     fifo_head;
  int unsigned       occ;

  always_comb begin
    // Redirect/halt discard everything buffered or in flight in the same cycle.
    kill     = (state_q == ST_RUN) && (redirect || halt);
    flush    = (state_q != ST_RUN) || redirect || halt;
    if_valid = (state_q == ST_RUN) && !kill && !fifo_empty;
    pop      = if_valid && if_ready;
    push     = vld_q[RD_LAT-1];
    occ      = 32'(fifo_cnt);
    for (int unsigned i = 0; i < RD_LAT; i++) occ += 32'(vld_q[i]);
    // A pop this cycle frees a slot before any new response can land, so it
    // is credited to keep one issue per cycle at minimum FIFO depth.
    issue    = (state_q == ST_RUN) && !kill && (occ < FIFO_DEPTH + 32'(pop));
    mem_we   = (state_q == ST_LOAD) && ld_valid;
    mem_re   = issue;
    mem_addr = mem_we ? ld_addr : pc_q;
    mem_wdata = mem_we ? ld_data : '0;
    ld_ready = (state_q == ST_LOAD);
    if_instr = if_valid ? fifo_head[EW-1:ADDR_W] : '0;
    if_pc    = if_valid ? fifo_head[ADDR_W-1:0] : '0;
  end

  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= reset_state(BOOT_LOAD);
      pc_q    <= ADDR_W'(RESET_PC);
      vld_q   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_done) begin
            state_q <= ST_RUN;
            pc_q    <= ADDR_W'(RESET_PC);
          end
        end
        ST_RUN: begin
          if (halt)          state_q <= ST_HALT;
          else if (redirect) pc_q    <= redirect_pc;
          else if (issue)    pc_q    <= pc_q + ADDR_W'(1);
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
      vld_q[0] <= issue;
      tag_q[0] <= pc_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1] && !kill;
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i ({mem_rdata, tag_q[RD_LAT-1]}),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
  import imem_ctrl_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n, ld_valid, ld_ready, ld_done;
  logic [AW-1:0] ld_addr, mem_addr, redirect_pc, if_pc;
  logic [31:0]   ld_data, mem_wdata, mem_rdata, if_instr;
  logic          mem_re, mem_we, redirect, halt, if_valid, if_ready;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W     (AW),
    .RD_LAT     (LAT),
    .FIFO_DEPTH (DEP),
    .RESET_PC   (0),
    .BOOT_LOAD  (1'b1)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_addr (ld_addr),
    .ld_data (ld_data), .ld_done (ld_done),
    .mem_addr (mem_addr), .mem_re (mem_re), .mem_we (mem_we),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .redirect (redirect), .redirect_pc (redirect_pc), .halt (halt),
    .if_valid (if_valid), .if_ready (if_ready), .if_instr (if_instr),
    .if_pc (if_pc), .state_o (state_o)
  );

  // Memory model with a two-cycle read pipeline (matches LAT).
  logic [31:0] mem [1024];
  logic [31:0] s1, rdq;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    s1  <= mem_re ? mem[mem_addr] : 32'hDEAD_BEEF;
    rdq <= s1;
  end
  assign mem_rdata = rdq;

  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    return (a < 10'd8) ? 32'h1000_0000 + 32'(a) : 32'hA500_0000 | 32'(a);
  endfunction

  int nvec = 0;
  int nerr = 0;
  int outs = 0;
  logic [AW-1:0] exp_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stream_step(input string tag, input logic ev);
    fetch_entry_t e;
    chk({tag, "_valid"}, if_valid, ev);
    chk({tag, "_re_we"}, mem_re & mem_we, 1'b0);
    if (ev && if_valid) begin
      e.pc    = exp_pc;
      e.instr = exp_word(exp_pc);
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_instr"}, if_instr, e.instr);
    end
    if (mem_re) outs++;
    if (if_valid && if_ready) begin
      outs--;
      exp_pc = exp_pc + 10'd1;
    end
  endtask

  typedef struct {
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          if_ready;
    logic          exp_we;
    logic          exp_re;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic          exp_ld_ready;
    logic [1:0]    exp_state;
  } vec_t;

  vec_t vt [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'hA500_0000 | 32'(a);

    // Boot-load vectors: idle, 8 writes (last with ld_done), first RUN cycle.
    vt[0] = '{1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 2'd0};
    for (int k = 0; k < 8; k++)
      vt[k+1] = '{1'b1, 10'(k), 32'h1000_0000 + 32'(k), (k == 7), 1'b0,
                  1'b1, 1'b0, 10'(k), 32'h1000_0000 + 32'(k), 1'b1, 2'd0};
    vt[9] = '{1'b1, 10'd5, 32'hDEAD_0005, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 32'h0, 1'b0, 2'd1};

    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0; if_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state_o, 2'd0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_mem_addr", mem_addr, 10'd0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 10'd0);
    rst_n = 1'b1;

    // Boot load table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ld_valid = vt[i].ld_valid; ld_addr = vt[i].ld_addr; ld_data = vt[i].ld_data;
      ld_done = vt[i].ld_done;   if_ready = vt[i].if_ready;
      #1;
      chk($sformatf("v%0d_we", i), mem_we, vt[i].exp_we);
      chk($sformatf("v%0d_re", i), mem_re, vt[i].exp_re);
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].exp_addr);
      if (vt[i].exp_we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp_wdata);
      chk($sformatf("v%0d_ld_ready", i), ld_ready, vt[i].exp_ld_ready);
      chk($sformatf("v%0d_state", i), state_o, vt[i].exp_state);
      chk($sformatf("v%0d_if_valid", i), if_valid, 1'b0);
    end
    ld_valid = 1'b0; ld_done = 1'b0;
    exp_pc = '0;
    outs = 1;

    // Streaming: first word LAT+1 cycles after RUN entry, then one per cycle
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      stream_step("stream", c >= 3);
    end

    // Back-pressure for 10 cycles, then release
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if_ready = 1'b0; #1;
      stream_step("bp", 1'b1);
      chk("bp_outstanding_le_depth", outs <= int'(DEP), 1'b1);
      if (c == 9) begin
        chk("bp_stalled_re", mem_re, 1'b0);
        chk("bp_outstanding_full", outs, 64'(DEP));
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); if_ready = 1'b1; #1;
      stream_step("bp_release", 1'b1);
    end

    // Redirect with words buffered; the pop in the redirect cycle is dropped
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); if_ready = 1'b0; #1;
      stream_step("redir_pre", 1'b1);
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 10'h200; if_ready = 1'b1; #1;
    chk("redir_if_valid", if_valid, 1'b0);
    chk("redir_mem_re", mem_re, 1'b0);
    @(negedge clk); redirect = 1'b0;
    exp_pc = 10'h200; outs = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      stream_step("redir", c >= 4);
    end

    // Wrap 0x3FF -> 0x000
    @(negedge clk); redirect = 1'b1; redirect_pc = 10'h3FF; #1;
    chk("wrap_redir_if_valid", if_valid, 1'b0);
    @(negedge clk); redirect = 1'b0;
    exp_pc = 10'h3FF;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      stream_step("wrap", c >= 4);
    end

    // Halt together with redirect: halt wins, then sticky
    @(negedge clk); halt = 1'b1; redirect = 1'b1; redirect_pc = 10'h100; #1;
    chk("halt_cyc_if_valid", if_valid, 1'b0);
    chk("halt_cyc_mem_re", mem_re, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); halt = 1'b0; redirect = (c == 2); redirect_pc = 10'h050; #1;
      chk($sformatf("halt%0d_state", c), state_o, 2'd2);
      chk($sformatf("halt%0d_if_valid", c), if_valid, 1'b0);
      chk($sformatf("halt%0d_mem_re", c), mem_re, 1'b0);
    end
    redirect = 1'b0;

    // Reset out of HALT, reload (no writes), stream, then reset mid-RUN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_halt_state", state_o, 2'd0);
    ld_done = 1'b1;
    @(negedge clk); ld_done = 1'b0; #1;
    chk("run2_state", state_o, 2'd1);
    chk("run2_mem_addr", mem_addr, 10'd0);
    exp_pc = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      stream_step("run2", c >= 3);
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst_state", state_o, 2'd0);
    chk("midrst_if_valid", if_valid, 1'b0);
    chk("midrst_ld_ready", ld_ready, 1'b1);
    chk("midrst_mem_re", mem_re, 1'b0);
    ld_done = 1'b1;
    @(negedge clk); ld_done = 1'b0; #1;
    chk("run3_state", state_o, 2'd1);
    exp_pc = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      stream_step("run3", c >= 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
